// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and stall/issue response bundle for the hazard scoreboard.
// The master side is the ID stage; the slave side is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NREGS = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_regWrite;
  logic             id_memRead;
  logic             id_isMul;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regWrite, id_memRead, id_isMul, flush,
    input  stall, issue, busy_vec
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_regWrite, id_memRead, id_isMul, flush,
    output stall, issue, busy_vec
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending counters that stall ID until long-latency results can be forwarded.
// Optional STALL_STATS_EN adds stall_cycles/raw_stalls performance counters.
module hazard_scoreboard #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MUL_LAT  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  hazard_scoreboard_if.slave sb
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        raw_stalls
`endif
);

  localparam logic [4:0] Xzr = 5'd31;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] lat;
  logic             raw, waw, stall, issue;

  always_comb begin
    lat = '0;
    if (sb.id_isMul) begin
      lat = CNT_W'(MUL_LAT);
    end else if (sb.id_memRead) begin
      lat = CNT_W'(LOAD_LAT);
    end
  end

  always_comb begin
    raw   = (sb.id_rs1_used && (sb.id_rs1 != Xzr) && (cnt_q[sb.id_rs1] != '0)) ||
            (sb.id_rs2_used && (sb.id_rs2 != Xzr) && (cnt_q[sb.id_rs2] != '0));
    // An older write still outstanding past our own latency would retire after us.
    waw   = sb.id_regWrite && (sb.id_rd != Xzr) && (cnt_q[sb.id_rd] > lat);
    stall = sb.id_valid && !sb.flush && (raw || waw);
    issue = sb.id_valid && !stall && !sb.flush;
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d[i] = '0;
      if (!sb.flush && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    if (issue && sb.id_regWrite && (sb.id_rd != Xzr)) begin
      cnt_d[sb.id_rd] = lat;
    end
    cnt_d[NREGS-1] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sb.stall    = stall;
    sb.issue    = issue;
    sb.busy_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      sb.busy_vec[i] = (cnt_q[i] != '0);
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] raw_stalls_q, raw_stalls_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + 32'(stall);
    raw_stalls_d   = raw_stalls_q + 32'(stall && raw);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      raw_stalls_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      raw_stalls_q   <= raw_stalls_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign raw_stalls   = raw_stalls_q;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Producer-side companion to the EX-stage operand forwarding logic in the pipelined LEGv8 core. It sits in ID and tracks in-flight destination registers whose results are not yet available on a forwarding path (loads, multi-cycle multiply). It stalls the instruction in ID until every source operand can be forwarded or read from the register file. X31 (XZR) is never tracked.

Parameters:
NREGS, 32, number of architectural registers tracked (index 31 = XZR)
CNT_W, 3, width of each per-register pending counter
LOAD_LAT, 1, extra cycles a load result needs before it can be forwarded
MUL_LAT, 4, extra cycles a multiply result needs before it can be forwarded (must be < 2**CNT_W)

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  5  first source register
id_rs2  in  5  second source register
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  5  destination register
id_regWrite  in  1  instruction writes rd
id_memRead  in  1  instruction is a load
id_isMul  in  1  instruction is a multi-cycle multiply
flush  in  1  branch taken / pipeline flush
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
issue  out  1  instruction leaves ID this cycle
busy_vec  out  NREGS  bit i = register i has pending counter != 0

Behaviour:
- State: cnt[i], CNT_W bits, i = 0..NREGS-1. cnt[31] is hard-wired to 0.
- Reset (reset_n low, asynchronous): all cnt = 0. Consequently stall = 0, issue = id_valid, busy_vec = 0.
- New-op latency L: MUL_LAT if id_isMul; else LOAD_LAT if id_memRead; else 0.
  - id_isMul has priority over id_memRead.
  - Single-cycle ALU ops are fully covered by forwarding, so L = 0.
- stall (combinational) = id_valid && !flush && (RAW || WAW).
  - RAW = (id_rs1_used && id_rs1 != 31 && cnt[id_rs1] != 0) || (id_rs2_used && id_rs2 != 31 && cnt[id_rs2] != 0).
  - WAW = id_regWrite && id_rd != 31 && cnt[id_rd] > L. This prevents a younger write from retiring before an older one.
- issue = id_valid && !stall && !flush.
- Each cycle, every nonzero cnt decrements by 1, saturating at 0.
- On issue with id_regWrite && id_rd != 31: cnt[id_rd] <= L. This overrides the decrement for that register in the same cycle.
- Consumer timing: a consumer issues in the cycle after its producer's counter reads 1, when the counter is 0. The forwarding path then supplies the value.
  - Load-use gives exactly 1 stall cycle with LOAD_LAT=1.
  - Multiply-use back-to-back gives MUL_LAT stall cycles.
- flush: synchronous; all cnt <= 0 next edge. Has priority over issue in the same cycle; issue = 0 and stall = 0 while flush = 1. In-flight ops are killed by the pipeline, so clearing is safe.
- Same register as rs and rd with rd pending: RAW rule governs (stall).
- id_valid = 0: stall = 0, issue = 0, counters still decrement.
- busy_vec[i] = (cnt[i] != 0), taken from registered state.

Optional Feature:
STALL_STATS_EN: when defined, adds output stall_cycles (32 bits) and output raw_stalls (32 bits).
- stall_cycles increments every cycle stall = 1.
- raw_stalls increments every cycle stall = 1 due to RAW.
- Both are cleared asynchronously by reset_n and are unaffected by flush. They wrap modulo 2**32.
- When not defined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Load-use: issue LDUR X2 (rd=2, memRead), then ADD X3,X2,X4 → stall=1 for exactly 1 cycle; ADD issues the next cycle; busy_vec[2]=1 for 1 cycle.
- ALU back-to-back: ADD X5,…, then SUB X6,X5,X5 → stall never asserted; issue=1 both cycles.
- Multiply: MUL X7 (isMul), then ADD X8,X7,X1 → stall=1 for 4 cycles (MUL_LAT=4); issue on cycle 5.
- XZR: LDUR X31, then ADD X1,X31,X31 → no stall; busy_vec stays 0.
- WAW + flush: MUL X9, then LDUR X9 → stall (cnt 4 > 1). Assert flush during stall → cnt cleared, issue=0 that cycle. LDUR issues the next cycle with no stall.
- Reset mid-op: MUL X10 issued, reset_n low 2 cycles later → busy_vec=0 immediately. ADD X11,X10,X10 after release issues without stall. With STALL_STATS_EN, stall_cycles=0 after reset.
